// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port.
// Takes a command (addr, len) and len payload bytes, buffers them, then
// drives header, payload and parity on the router pkt_valid/data_in
// interface, holding the presented byte while busy is high.
// Optional feature macro: ROUTER_TX_PARITY_ERR_EN adds input inject_err,
// sampled at command accept, which inverts bit 0 of the sent parity byte.
// MAX_LEN must be <= 63 (6-bit length field); GAP_CYCLES must be >= 1.
module router_pkt_tx #(
  parameter int unsigned MAX_LEN    = 63,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_ready,
  output logic       cmd_err,
`ifdef ROUTER_TX_PARITY_ERR_EN
  input  logic       inject_err,
`endif
  input  logic       pay_valid,
  input  logic [7:0] pay_data,
  output logic       pay_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] par_q, par_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic [7:0] par_tx;

  logic       cmd_ready_d, cmd_err_d, pay_ready_d, pkt_valid_d;
  logic [7:0] data_out_d;
  logic       tx_active_d, tx_done_d;

  logic [7:0] mem [MAX_LEN];

  logic       load_take;
  assign load_take = (state_q == LOAD) && pay_valid && pay_ready;

`ifdef ROUTER_TX_PARITY_ERR_EN
  logic inj_q, inj_d;
  assign par_tx = par_q ^ {7'b0, inj_q};
`else
  assign par_tx = par_q;
`endif

  // Payload buffer write; contents need no reset.
  always_ff @(posedge clock) begin
    if (load_take) mem[cnt_q] <= pay_data;
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      hdr_q     <= '0;
      par_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      gcnt_q    <= '0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      pay_ready <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_EN
      inj_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_q     <= hdr_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      cmd_ready <= cmd_ready_d;
      cmd_err   <= cmd_err_d;
      pay_ready <= pay_ready_d;
      pkt_valid <= pkt_valid_d;
      data_out  <= data_out_d;
      tx_active <= tx_active_d;
      tx_done   <= tx_done_d;
`ifdef ROUTER_TX_PARITY_ERR_EN
      inj_q     <= inj_d;
`endif
    end
  end

  // Next state and next output values; outputs are computed one cycle
  // ahead so that every port is driven straight from a flop.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_d       = hdr_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    gcnt_d      = gcnt_q;
    cmd_ready_d = 1'b0;
    cmd_err_d   = 1'b0;
    pay_ready_d = 1'b0;
    pkt_valid_d = pkt_valid;
    data_out_d  = data_out;
    tx_active_d = tx_active;
    tx_done_d   = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_EN
    inj_d       = inj_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
        tx_active_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          if (cmd_addr == 2'b11 || cmd_len == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            len_d       = cmd_len;
            hdr_d       = {cmd_len, cmd_addr};
            par_d       = {cmd_len, cmd_addr};
            cnt_d       = '0;
            state_d     = LOAD;
            cmd_ready_d = 1'b0;
            pay_ready_d = 1'b1;
            tx_active_d = 1'b1;
`ifdef ROUTER_TX_PARITY_ERR_EN
            inj_d       = inject_err;
`endif
          end
        end
      end
      LOAD: begin
        pay_ready_d = 1'b1;
        if (load_take) begin
          par_d = par_q ^ pay_data;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) begin
            state_d     = HDR;
            pay_ready_d = 1'b0;
            pkt_valid_d = 1'b1;
            data_out_d  = hdr_q;
          end
        end
      end
      HDR: begin
        if (!busy) begin
          state_d    = PAY;
          idx_d      = '0;
          data_out_d = mem[0];
        end
      end
      PAY: begin
        if (!busy) begin
          if (idx_q == len_q - 6'd1) begin
            state_d     = PAR;
            pkt_valid_d = 1'b0;
            data_out_d  = par_tx;
          end else begin
            idx_d      = idx_q + 6'd1;
            data_out_d = mem[idx_q + 6'd1];
          end
        end
      end
      PAR: begin
        if (!busy) begin
          state_d    = GAP;
          tx_done_d  = 1'b1;
          data_out_d = '0;
          gcnt_d     = '0;
        end
      end
      GAP: begin
        data_out_d = '0;
        if (gcnt_q == GAP_LAST) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          tx_active_d = 1'b0;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: scoreboard bench for router_pkt_tx. Stimulus pushes the
// expected router-side byte stream into a queue; a negedge monitor pops and
// compares every byte the router accepts and checks bytes held under busy.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic       cmd_ready, cmd_err;
  logic       pay_valid = 1'b0;
  logic [7:0] pay_data = '0;
  logic       pay_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active, tx_done;
`ifdef ROUTER_TX_PARITY_ERR_EN
  logic       inject_err = 1'b0;
`endif

  always #5 clock = ~clock;

  router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err),
`ifdef ROUTER_TX_PARITY_ERR_EN
    .inject_err(inject_err),
`endif
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
    .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
    .tx_active(tx_active), .tx_done(tx_done)
  );

  typedef struct packed {logic pv; logic [7:0] d;} exp_t;
  exp_t sb[$];
  exp_t e;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] pay_buf [64];
  logic mon_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, req);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: a byte is on offer while pkt_valid is high or during the
  // parity cycle(s) right after pkt_valid falls; it is taken when busy is low.
  logic prev_pv = 1'b0, par_pend = 1'b0, held = 1'b0, held_pv = 1'b0;
  logic [7:0] held_d = '0;
  logic present;
  always @(negedge clock) begin
    if (!mon_en || reset) begin
      prev_pv  = 1'b0;
      par_pend = 1'b0;
      held     = 1'b0;
    end else begin
      present = pkt_valid || prev_pv || par_pend;
      if (held) begin
        chk8("hold_data", data_out, held_d);
        chk1("hold_valid", pkt_valid, held_pv);
      end
      if (present) begin
        if (!busy) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: got pv=%0b data=0x%02h, expected none",
                     pkt_valid, data_out);
          end else begin
            e = sb.pop_front();
            chk1("byte_pv", pkt_valid, e.pv);
            chk8("byte_data", data_out, e.d);
          end
          held     = 1'b0;
          par_pend = 1'b0;
        end else begin
          held     = 1'b1;
          held_d   = data_out;
          held_pv  = pkt_valid;
          par_pend = !pkt_valid;
        end
      end else begin
        held = 1'b0;
      end
      prev_pv = pkt_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic pv, input logic [7:0] d);
    exp_t x;
    x.pv = pv;
    x.d  = d;
    sb.push_back(x);
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk1("cmd_ready_wait", n < 50, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load(input int len, input bit toggle);
    int n;
    for (int i = 0; i < len; i++) begin
      if (toggle && i > 0) begin
        pay_valid = 1'b0;
        tick();
        chk1("load_no_pkt_valid_gap", pkt_valid, 1'b0);
      end
      n = 0;
      while (!pay_ready && n < 50) begin tick(); n++; end
      chk1("pay_ready", pay_ready, 1'b1);
      chk1("load_no_pkt_valid", pkt_valid, 1'b0);
      pay_valid = 1'b1;
      pay_data  = pay_buf[i];
      tick();
    end
    pay_valid = 1'b0;
    chk1("pay_ready_drop", pay_ready, 1'b0);
  endtask

  task automatic wait_done(input string nm, input int exp_cycles);
    int n = 0;
    while (!tx_done && n < 300) begin tick(); n++; end
    chki(nm, n, exp_cycles);
  endtask

  task automatic gap_check();
    chk1("gap0_cmd_ready", cmd_ready, 1'b0);
    chk1("gap0_pkt_valid", pkt_valid, 1'b0);
    chk8("gap0_data", data_out, 8'h00);
    tick();
    chk1("gap1_tx_done", tx_done, 1'b0);
    chk1("gap1_cmd_ready", cmd_ready, 1'b0);
    chk1("gap1_tx_active", tx_active, 1'b1);
    tick();
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    chk1("idle_tx_active", tx_active, 1'b0);
  endtask

  task automatic pkt_a_setup();
    pay_buf[0] = 8'h11;
    pay_buf[1] = 8'h22;
    pay_buf[2] = 8'h33;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(); tick(); tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_cmd_err", cmd_err, 1'b0);
    chk1("rst_pay_ready", pay_ready, 1'b0);
    chk1("rst_pkt_valid", pkt_valid, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_tx_active", tx_active, 1'b0);
    chk1("rst_tx_done", tx_done, 1'b0);
    reset = 1'b0;
    tick();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
    mon_en = 1'b1;

    // 1: addr 1, len 3, no back-pressure
    pkt_a_setup();
    send_cmd(2'd1, 6'd3);
    chk1("t1_tx_active", tx_active, 1'b1);
    chk1("t1_cmd_ready_low", cmd_ready, 1'b0);
    push(1'b1, 8'h0D); push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33);
    push(1'b0, 8'h0D);
    load(3, 1'b0);
    chk1("t1_hdr_valid", pkt_valid, 1'b1);
    chk8("t1_hdr_data", data_out, 8'h0D);
    wait_done("t1_cycles_to_done", 5);
    gap_check();

    // 2: same packet with busy on header (2 cycles) and on 0x22 (1 cycle)
    pkt_a_setup();
    send_cmd(2'd1, 6'd3);
    push(1'b1, 8'h0D); push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33);
    push(1'b0, 8'h0D);
    load(3, 1'b0);
    chk8("t2_hdr", data_out, 8'h0D);
    busy = 1'b1;
    tick();
    chk8("t2_hdr_hold1", data_out, 8'h0D);
    tick();
    chk8("t2_hdr_hold2", data_out, 8'h0D);
    busy = 1'b0;
    tick();
    chk8("t2_byte0", data_out, 8'h11);
    tick();
    chk8("t2_byte1", data_out, 8'h22);
    busy = 1'b1;
    tick();
    chk8("t2_byte1_hold", data_out, 8'h22);
    chk1("t2_pv_hold", pkt_valid, 1'b1);
    busy = 1'b0;
    wait_done("t2_cycles_to_done", 3);
    gap_check();

    // 3: illegal commands
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd4;
    tick();
    cmd_valid = 1'b0;
    chk1("t3a_cmd_err", cmd_err, 1'b1);
    chk1("t3a_cmd_ready", cmd_ready, 1'b1);
    chk1("t3a_pay_ready", pay_ready, 1'b0);
    chk1("t3a_pkt_valid", pkt_valid, 1'b0);
    tick();
    chk1("t3a_cmd_err_pulse", cmd_err, 1'b0);
    chk1("t3a_pay_ready2", pay_ready, 1'b0);
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd0;
    tick();
    cmd_valid = 1'b0;
    chk1("t3b_cmd_err", cmd_err, 1'b1);
    chk1("t3b_pay_ready", pay_ready, 1'b0);
    chk1("t3b_tx_active", tx_active, 1'b0);
    tick();
    chk1("t3b_cmd_err_pulse", cmd_err, 1'b0);
    chk1("t3b_pkt_valid", pkt_valid, 1'b0);

    // 4: maximum length with pay_valid gaps; parity 0xFE ^ 0x3F = 0xC1
    for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i);
    send_cmd(2'd2, 6'd63);
    push(1'b1, 8'hFE);
    for (int i = 0; i < 63; i++) push(1'b1, 8'(i));
    push(1'b0, 8'hC1);
    load(63, 1'b1);
    chk1("t4_hdr_valid", pkt_valid, 1'b1);
    chk8("t4_hdr_data", data_out, 8'hFE);
    wait_done("t4_cycles_to_done", 65);
    gap_check();
    chki("sb_drained_before_reset", sb.size(), 0);

    // 5: reset while the 5th payload byte is on data_out
    mon_en = 1'b0;
    for (int i = 0; i < 8; i++) pay_buf[i] = 8'hA0 + 8'(i);
    send_cmd(2'd1, 6'd8);
    load(8, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk8("t5_byte4", data_out, 8'hA4);
    chk1("t5_byte4_pv", pkt_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk1("t5_rst_pkt_valid", pkt_valid, 1'b0);
    chk8("t5_rst_data", data_out, 8'h00);
    chk1("t5_rst_cmd_ready", cmd_ready, 1'b0);
    chk1("t5_rst_tx_active", tx_active, 1'b0);
    reset = 1'b0;
    tick();
    chk1("t5_idle_cmd_ready", cmd_ready, 1'b1);
    chk1("t5_idle_pkt_valid", pkt_valid, 1'b0);
    mon_en = 1'b1;

`ifdef ROUTER_TX_PARITY_ERR_EN
    // 6: corrupted parity, then a clean packet
    pkt_a_setup();
    inject_err = 1'b1;
    send_cmd(2'd1, 6'd3);
    inject_err = 1'b0;
    push(1'b1, 8'h0D); push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33);
    push(1'b0, 8'h0C);
    load(3, 1'b0);
    wait_done("t6a_cycles_to_done", 5);
    gap_check();
    send_cmd(2'd1, 6'd3);
    push(1'b1, 8'h0D); push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33);
    push(1'b0, 8'h0D);
    load(3, 1'b0);
    wait_done("t6b_cycles_to_done", 5);
    gap_check();
`endif

    tick();
    chki("sb_drained_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
